// File: rtl/hello_cpu_0_debug_mem_seq.sv
// OCI debug-memory sequencer: turns debug-slave strobes into single-word RAM
// reads/writes with address post-increment, read-latency tracking and a sticky collision flag.
module hello_cpu_0_debug_mem_seq #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [31:0]       ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  // Read wait counter starts at RD_LAT and captures when it reaches zero,
  // giving capture at edge RD_LAT+1 after the accept edge.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  logic [1:0]        state_q,     state_d;
  logic [1:0]        lat_cnt_q,   lat_cnt_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_we_q,    ram_we_d;
  logic              ram_re_q,    ram_re_d;
  logic [31:0]       mon_q,       mon_d;
  logic              ready_q,     ready_d;
  logic              error_q,     error_d;

  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              cmd_rd_on_load;
  logic              cmd_err_clr;
  logic              is_idle;
  logic              any_strobe;
  logic              multi_strobe;
  logic              go_a;
  logic              go_b;
  logic              go_n;
  logic              err_set;
  logic              err_clr;
  logic              unused_jdo;

  assign cmd_addr       = jdo[ADDR_W+16:17];
  assign cmd_wdata      = jdo[34:3];
  assign cmd_rd_on_load = jdo[35];
  assign cmd_err_clr    = jdo[36];
  assign unused_jdo     = ^{jdo[37], jdo[2:0]};

  assign is_idle      = (state_q == ST_IDLE);
  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);

  // Fixed priority a > b > no_action; only the winner is accepted, and only in IDLE.
  assign go_a = is_idle & take_action_ocimem_a;
  assign go_b = is_idle & take_action_ocimem_b & ~take_action_ocimem_a;
  assign go_n = is_idle & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

  assign err_set = (~is_idle & any_strobe) | (is_idle & multi_strobe);
  assign err_clr = go_a & cmd_err_clr;

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    mon_d       = mon_q;
    ready_d     = ready_q;

    case (state_q)
      ST_IDLE: begin
        if (go_a) begin
          addr_d = cmd_addr;
          if (cmd_rd_on_load) begin
            ram_addr_d = cmd_addr;
            ram_re_d   = 1'b1;
            ready_d    = 1'b0;
            lat_cnt_d  = LAT_INIT;
            state_d    = ST_RD_WAIT;
          end
        end else if (go_b) begin
          ram_addr_d  = addr_q;
          ram_wdata_d = cmd_wdata;
          ram_we_d    = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          ready_d     = 1'b0;
          state_d     = ST_WRITE;
        end else if (go_n) begin
          ram_addr_d = addr_q;
          ram_re_d   = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          ready_d    = 1'b0;
          lat_cnt_d  = LAT_INIT;
          state_d    = ST_RD_WAIT;
        end
      end
      ST_WRITE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          mon_d   = ram_rdata;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A clear wins over a set sampled at the same edge.
  always_comb begin
    error_d = error_q;
    if (err_clr) begin
      error_d = 1'b0;
    end else if (err_set) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= 2'd0;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      mon_q       <= 32'h0;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      mon_q       <= mon_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign ram_re        = ram_re_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_hello_cpu_0_debug_mem_seq.sv
// Bench for hello_cpu_0_debug_mem_seq: two instances (RD_LAT=1 and RD_LAT=3) share stimulus,
// each with its own RAM model; results are compared against a behavioural model of the command rules.
module tb_hello_cpu_0_debug_mem_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_mem;
  logic [37:0] jdo;
  logic        take_a, take_b, take_n;
  logic [31:0] rdata [2];
  logic [7:0]  raddr [2];
  logic [31:0] wdata [2];
  logic        we    [2];
  logic        re    [2];
  logic [31:0] mon   [2];
  logic        rdy   [2];
  logic        err   [2];

  logic [31:0] init_mem [256];
  logic [31:0] m_mem    [256];
  logic [7:0]  m_addr;
  logic [31:0] m_mon;
  logic        m_err;
  logic [40:0] act_q [2][$];
  logic [40:0] exp_q [$];
  int          mark  [2];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  hello_cpu_0_debug_mem_seq #(.ADDR_W(8), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_n), .ram_rdata(rdata[0]),
    .ram_addr(raddr[0]), .ram_wdata(wdata[0]), .ram_we(we[0]), .ram_re(re[0]),
    .MonDReg(mon[0]), .monitor_ready(rdy[0]), .monitor_error(err[0])
  );

  hello_cpu_0_debug_mem_seq #(.ADDR_W(8), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_n), .ram_rdata(rdata[1]),
    .ram_addr(raddr[1]), .ram_wdata(wdata[1]), .ram_we(we[1]), .ram_re(re[1]),
    .MonDReg(mon[1]), .monitor_ready(rdy[1]), .monitor_error(err[1])
  );

  // Synchronous RAM models; data outside the read slot is a poison pattern.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
      if (load_mem) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
      end else if (we[g]) begin
        mem[raddr[g]] <= wdata[g];
      end
      pipe[0] <= re[g] ? mem[raddr[g]] : (32'hBAD0_0000 + 32'(g));
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata[g] = pipe[LAT-1];
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        if (we[d]) act_q[d].push_back({1'b1, raddr[d], wdata[d]});
        if (re[d]) act_q[d].push_back({1'b0, raddr[d], 32'h0});
      end
    end
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [37:0] jdo_rand();
    return 38'({$urandom(), $urandom()});
  endfunction

  function automatic logic [37:0] jdo_a(input logic [7:0] ad, input logic rd, input logic clr);
    logic [37:0] j;
    j = jdo_rand();
    j[24:17] = ad;
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] dat);
    logic [37:0] j;
    j = jdo_rand();
    j[34:3] = dat;
    return j;
  endfunction

  // Apply strobes now (at a negedge) for exactly one posedge.
  task automatic drive_now(input logic a, input logic b, input logic n, input logic [37:0] j);
    take_a = a; take_b = b; take_n = n; jdo = j;
    @(negedge clk);
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0; jdo = jdo_rand();
  endtask

  task automatic drive(input logic a, input logic b, input logic n, input logic [37:0] j);
    @(negedge clk);
    drive_now(a, b, n, j);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (!(rdy[0] && rdy[1]) && i < 20) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (!(rdy[0] && rdy[1])) $display("FAIL idle_timeout ready=%b%b required 11", rdy[0], rdy[1]);
    else n_pass++;
  endtask

  task automatic take_marks();
    for (int d = 0; d < 2; d++) mark[d] = act_q[d].size();
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({mon[d], rdy[d], err[d], we[d], re[d], raddr[d], wdata[d]} !==
          {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0})
        $display("FAIL reset_vals dut%0d got mon=%h rdy=%b err=%b we=%b re=%b addr=%h wdata=%h required 0/1/0/0/0/0/0",
                 d, mon[d], rdy[d], err[d], we[d], re[d], raddr[d], wdata[d]);
      else n_pass++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_addr = 8'h0; m_mon = 32'h0; m_err = 1'b0;
  endtask

  task automatic test_write();
    drive(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b0, 1'b0));
    m_addr = 8'h10;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({rdy[d], re[d], we[d]} !== 3'b100) $display("FAIL load_only dut%0d got rdy/re/we=%b%b%b required 100", d, rdy[d], re[d], we[d]);
      else n_pass++;
    end
    drive(1'b0, 1'b1, 1'b0, jdo_b(32'hDEADBEEF));
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({we[d], re[d], raddr[d], wdata[d], rdy[d]} !== {1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0})
        $display("FAIL wr_pulse dut%0d got we=%b re=%b addr=%h wdata=%h rdy=%b required 1 0 10 deadbeef 0",
                 d, we[d], re[d], raddr[d], wdata[d], rdy[d]);
      else n_pass++;
    end
    m_mem[8'h10] = 32'hDEADBEEF;
    m_addr = 8'h11;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({we[d], rdy[d]} !== 2'b01) $display("FAIL wr_done dut%0d got we/rdy=%b%b required 01", d, we[d], rdy[d]);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b1, jdo_rand());
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({re[d], raddr[d]} !== {1'b1, m_addr}) $display("FAIL rd_incr_addr dut%0d got re=%b addr=%h required 1 %h", d, re[d], raddr[d], m_addr);
      else n_pass++;
    end
    wait_idle();
    m_mon = m_mem[m_addr];
    m_addr = m_addr + 8'd1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (mon[d] !== m_mon) $display("FAIL rd_incr_data dut%0d got %h required %h", d, mon[d], m_mon);
      else n_pass++;
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] prev;
    logic        exp_rdy;
    prev = m_mon;
    drive(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1, 1'b0));
    m_addr = 8'h10;
    m_mon = m_mem[8'h10];
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({re[d], raddr[d]} !== {1'b1, 8'h10}) $display("FAIL ld_rd_issue dut%0d got re=%b addr=%h required 1 10", d, re[d], raddr[d]);
      else n_pass++;
    end
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_rdy = (k >= lat_of(d) + 1);
        n_checks++;
        if ({rdy[d], mon[d]} !== {exp_rdy, exp_rdy ? m_mon : prev})
          $display("FAIL rd_latency dut%0d edge%0d got rdy=%b mon=%h required %b %h",
                   d, k, rdy[d], mon[d], exp_rdy, exp_rdy ? m_mon : prev);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [3];
    seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'h01;
    drive(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0, 1'b0));
    m_addr = 8'hFF;
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b0, 1'b1, jdo_rand());
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({re[d], raddr[d]} !== {1'b1, seq[s]}) $display("FAIL wrap_addr dut%0d step%0d got %h required %h", d, s, raddr[d], seq[s]);
        else n_pass++;
      end
      wait_idle();
      m_mon = m_mem[m_addr];
      m_addr = m_addr + 8'd1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({mon[d], err[d]} !== {m_mon, 1'b0}) $display("FAIL wrap_data dut%0d got mon=%h err=%b required %h 0", d, mon[d], err[d], m_mon);
        else n_pass++;
      end
    end
  endtask

  task automatic test_collision_busy();
    logic [7:0]  at;
    logic [31:0] dat;
    take_marks();
    at = m_addr;
    drive(1'b0, 1'b0, 1'b1, jdo_rand());
    drive_now(1'b0, 1'b1, 1'b0, jdo_b($urandom()));
    wait_idle();
    m_mon = m_mem[at];
    m_addr = m_addr + 8'd1;
    m_err = 1'b1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (!(act_q[d].size() == mark[d] + 1 && act_q[d][mark[d]] == {1'b0, at, 32'h0}))
        $display("FAIL busy_log dut%0d got %0d accesses required 1 read at %h", d, act_q[d].size() - mark[d], at);
      else n_pass++;
      n_checks++;
      if ({mon[d], err[d]} !== {m_mon, m_err}) $display("FAIL busy_rd_err dut%0d got mon=%h err=%b required %h %b", d, mon[d], err[d], m_mon, m_err);
      else n_pass++;
    end
    dat = $urandom();
    at = m_addr;
    drive(1'b0, 1'b1, 1'b0, jdo_b(dat));
    drive_now(1'b1, 1'b0, 1'b0, jdo_a(8'h55, 1'b0, 1'b0));
    wait_idle();
    m_mem[at] = dat;
    m_addr = m_addr + 8'd1;
    drive(1'b0, 1'b0, 1'b1, jdo_rand());
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (raddr[d] !== m_addr) $display("FAIL busy_ld_dropped dut%0d got addr=%h required %h", d, raddr[d], m_addr);
      else n_pass++;
    end
    wait_idle();
    m_mon = m_mem[m_addr];
    m_addr = m_addr + 8'd1;
    drive(1'b1, 1'b0, 1'b0, jdo_a(8'h40, 1'b0, 1'b1));
    m_addr = 8'h40;
    m_err = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({mon[d], err[d], rdy[d]} !== {m_mon, 1'b0, 1'b1}) $display("FAIL err_clear dut%0d got mon=%h err=%b rdy=%b required %h 0 1", d, mon[d], err[d], rdy[d], m_mon);
      else n_pass++;
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0]  at;
    logic [31:0] dat;
    take_marks();
    dat = $urandom();
    at = m_addr;
    drive(1'b0, 1'b1, 1'b1, jdo_b(dat));
    wait_idle();
    m_mem[at] = dat;
    m_addr = m_addr + 8'd1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (!(act_q[d].size() == mark[d] + 1 && act_q[d][mark[d]] == {1'b1, at, dat} && err[d] === 1'b1))
        $display("FAIL wr_beats_rd dut%0d got %0d accesses err=%b required 1 write at %h err=1", d, act_q[d].size() - mark[d], err[d], at);
      else n_pass++;
    end
    take_marks();
    drive(1'b1, 1'b0, 1'b1, jdo_a(8'h20, 1'b0, 1'b1));
    m_addr = 8'h20;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (!(act_q[d].size() == mark[d] && err[d] === 1'b0 && rdy[d] === 1'b1))
        $display("FAIL clr_beats_set dut%0d got %0d accesses err=%b rdy=%b required 0 0 1", d, act_q[d].size() - mark[d], err[d], rdy[d]);
      else n_pass++;
    end
    take_marks();
    drive(1'b1, 1'b1, 1'b0, jdo_a(8'h30, 1'b1, 1'b0));
    wait_idle();
    m_addr = 8'h30;
    m_mon = m_mem[8'h30];
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (!(act_q[d].size() == mark[d] + 1 && act_q[d][mark[d]] == {1'b0, 8'h30, 32'h0} && mon[d] === m_mon && err[d] === 1'b1))
        $display("FAIL a_beats_b dut%0d got %0d accesses mon=%h err=%b required 1 read mon=%h err=1", d, act_q[d].size() - mark[d], mon[d], err[d], m_mon);
      else n_pass++;
    end
    at = 8'($urandom());
    drive(1'b1, 1'b0, 1'b0, jdo_a(at, 1'b0, 1'b1));
    m_addr = at;
    m_err = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0]  ad;
    logic [31:0] dat;
    int          op;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      exp_q.delete();
      take_marks();
      ad = 8'($urandom());
      dat = $urandom();
      case (op)
        0: begin
          drive(1'b1, 1'b0, 1'b0, jdo_a(ad, 1'b0, 1'($urandom_range(0, 1))));
          m_addr = ad;
        end
        1: begin
          exp_q.push_back({1'b0, ad, 32'h0});
          m_mon = m_mem[ad];
          m_addr = ad;
          drive(1'b1, 1'b0, 1'b0, jdo_a(ad, 1'b1, 1'($urandom_range(0, 1))));
        end
        2: begin
          exp_q.push_back({1'b1, m_addr, dat});
          m_mem[m_addr] = dat;
          m_addr = m_addr + 8'd1;
          drive(1'b0, 1'b1, 1'b0, jdo_b(dat));
        end
        default: begin
          exp_q.push_back({1'b0, m_addr, 32'h0});
          m_mon = m_mem[m_addr];
          m_addr = m_addr + 8'd1;
          drive(1'b0, 1'b0, 1'b1, jdo_rand());
        end
      endcase
      wait_idle();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (act_q[d].size() != mark[d] + exp_q.size())
          $display("FAIL rnd_count dut%0d it%0d got %0d accesses required %0d", d, it, act_q[d].size() - mark[d], exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && mark[d] + i < act_q[d].size(); i++) begin
          n_checks++;
          if (act_q[d][mark[d] + i] !== exp_q[i]) $display("FAIL rnd_access dut%0d it%0d got %h required %h", d, it, act_q[d][mark[d] + i], exp_q[i]);
          else n_pass++;
        end
        n_checks++;
        if ({mon[d], err[d]} !== {m_mon, m_err}) $display("FAIL rnd_result dut%0d it%0d got mon=%h err=%b required %h %b", d, it, mon[d], err[d], m_mon, m_err);
        else n_pass++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    take_marks();
    drive(1'b0, 1'b0, 1'b1, jdo_rand());
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({mon[d], rdy[d], err[d], we[d], re[d], raddr[d], wdata[d]} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0})
        $display("FAIL async_reset dut%0d got mon=%h rdy=%b err=%b we=%b re=%b addr=%h wdata=%h required reset values",
                 d, mon[d], rdy[d], err[d], we[d], re[d], raddr[d], wdata[d]);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_addr = 8'h0; m_mon = 32'h0; m_err = 1'b0;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (!(mon[d] === 32'h0 && rdy[d] === 1'b1 && err[d] === 1'b0 && act_q[d].size() == mark[d] + 1))
        $display("FAIL post_reset dut%0d got mon=%h rdy=%b err=%b accesses=%0d required 0 1 0 1", d, mon[d], rdy[d], err[d], act_q[d].size() - mark[d]);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b1, jdo_rand());
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (raddr[d] !== 8'h0) $display("FAIL post_reset_addr dut%0d got %h required 00", d, raddr[d]);
      else n_pass++;
    end
    wait_idle();
  endtask

  initial begin
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
    jdo = '0;
    reset_n = 1'b0;
    load_mem = 1'b1;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = $urandom();
      m_mem[i] = init_mem[i];
    end
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    test_reset();
    test_write();
    test_read_latency();
    test_wrap();
    test_collision_busy();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
